axis_pkt_cap: RTL and testbench

AXIS_PKT_CAP -- requirements
Module: axis_pkt_cap

---
 rtl/axis_pkt_cap_if.sv | 21 ++
 rtl/axis_pkt_cap.sv | 155 +++++++++++++++
 tb/tb_axis_pkt_cap.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_cap_if.sv
`default_nettype none
// ============================================================================
// Interface   : AXIS_int
// Description : AXI-Stream bundle with byte-granular keep and sideband user.
// Revision    : 1.0 - initial release
// ============================================================================
interface AXIS_int #(
    parameter int DATA_BYTES = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tready;

    modport Master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport Slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_pkt_cap.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_cap
// Description : Captures one AXI-Stream packet into a flat MTU-sized buffer
//               and holds it until the consumer acknowledges it.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_cap #(
    parameter int MTU_BYTES = 1500
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    AXIS_int.Slave                               axis_packet_in,
    output logic                                 packet_valid,
    input  logic                                 packet_ack,
    output logic                                 busy,
    output int                                   packet_byte_length,
    output logic [axis_packet_in.USER_WIDTH-1:0] packet_user,
    output logic [MTU_BYTES*8-1:0]               packet_data,
    output logic                                 packet_overflow
);

    localparam int c_DATA_BYTES = axis_packet_in.DATA_BYTES;
    localparam int c_USER_WIDTH = axis_packet_in.USER_WIDTH;
    localparam int c_OFF_W      = $clog2(MTU_BYTES + 1);
    localparam int c_CNT_W      = $clog2(c_DATA_BYTES + 1);
    localparam int c_MEM_W      = MTU_BYTES * 8;

    generate
        if (c_DATA_BYTES < 1) begin : g_bad_data_bytes
            $error("axis_pkt_cap: DATA_BYTES must be >= 1");
        end
        if (MTU_BYTES <= 0) begin : g_bad_mtu
            $error("axis_pkt_cap: MTU_BYTES must be > 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_tready;
    logic                      r_overflow;
    logic [c_OFF_W-1:0]        r_offset;
    logic [c_USER_WIDTH-1:0]   r_user;
    logic [c_MEM_W-1:0]        r_data;

    logic                      w_accept;
    logic [c_CNT_W-1:0]        w_count;
    logic [31:0]               w_sum;
    logic                      w_over;
    logic [c_OFF_W-1:0]        w_offset_next;
    logic [c_OFF_W+2:0]        w_shift;
    logic [c_DATA_BYTES*8-1:0] w_lane_mask;
    logic [c_MEM_W-1:0]        w_wr_mask;
    logic [c_MEM_W-1:0]        w_wr_data;

    assign w_accept      = axis_packet_in.tvalid & r_tready;
    assign w_count       = c_CNT_W'($countones(axis_packet_in.tkeep));
    assign w_sum         = 32'(r_offset) + 32'(w_count);
    assign w_over        = (w_sum > 32'(MTU_BYTES));
    assign w_offset_next = w_over ? c_OFF_W'(MTU_BYTES) : c_OFF_W'(w_sum);

    generate
        for (genvar g = 0; g < c_DATA_BYTES; g++) begin : g_lane_mask
            assign w_lane_mask[g*8 +: 8] = {8{axis_packet_in.tkeep[g]}};
        end
    endgenerate

    // Lanes landing at or beyond MTU_BYTES fall off the top of the shift and are dropped
    assign w_shift   = {r_offset, 3'b000};
    assign w_wr_mask = c_MEM_W'(w_lane_mask) << w_shift;
    assign w_wr_data = c_MEM_W'(axis_packet_in.tdata & w_lane_mask) << w_shift;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = axis_packet_in.tlast ? S_HOLD : S_RECV;
                end
            end
            S_RECV: begin
                if (w_accept) begin
                    if (axis_packet_in.tlast) begin
                        w_state_next = S_HOLD;
                    end else if (w_over) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_accept && axis_packet_in.tlast) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (packet_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // tready is registered so it cannot rise before the first edge after reset release
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_tready <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_tready <= (w_state_next != S_HOLD);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_offset   <= '0;
            r_overflow <= 1'b0;
            r_user     <= '0;
            r_data     <= '0;
        end else if (r_state == S_HOLD) begin
            if (packet_ack) begin
                r_offset   <= '0;
                r_overflow <= 1'b0;
                r_data     <= '0;
            end
        end else if (w_accept) begin
            r_offset <= w_offset_next;
            r_data   <= (r_data & ~w_wr_mask) | w_wr_data;
            if (w_over) begin
                r_overflow <= 1'b1;
            end
            if (r_state == S_IDLE) begin
                r_user <= axis_packet_in.tuser;
            end
        end
    end

    assign axis_packet_in.tready = r_tready;
    assign packet_valid          = (r_state == S_HOLD);
    assign busy                  = (r_state != S_IDLE);
    assign packet_byte_length    = int'(r_offset);
    assign packet_user           = r_user;
    assign packet_data           = r_data;
    assign packet_overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_cap.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pkt_cap
// Description : Self-checking bench for axis_pkt_cap against a byte-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_cap;

    localparam int c_DB  = 8;
    localparam int c_UW  = 4;
    localparam int c_MTU = 1500;

    logic               clk        = 1'b0;
    logic               aresetn    = 1'b0;
    logic               packet_ack = 1'b0;
    logic               packet_valid;
    logic               busy;
    logic               packet_overflow;
    int                 packet_byte_length;
    logic [c_UW-1:0]    packet_user;
    logic [c_MTU*8-1:0] packet_data;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;

    // Reference model: every kept byte of the packet in arrival order
    logic [7:0]      m_bytes[$];
    int              m_total;
    logic [c_UW-1:0] m_user;
    int              keeps_q[$];

    AXIS_int #(.DATA_BYTES(c_DB), .USER_WIDTH(c_UW)) axis_if ();

    axis_pkt_cap #(.MTU_BYTES(c_MTU)) dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .axis_packet_in     (axis_if),
        .packet_valid       (packet_valid),
        .packet_ack         (packet_ack),
        .busy               (busy),
        .packet_byte_length (packet_byte_length),
        .packet_user        (packet_user),
        .packet_data        (packet_data),
        .packet_overflow    (packet_overflow)
    );

    always #5 clk = ~clk;

    function automatic int exp_len();
        return (m_total < c_MTU) ? m_total : c_MTU;
    endfunction

    function automatic logic exp_ovf();
        return (m_total > c_MTU);
    endfunction

    function automatic int bad_bytes();
        int         n;
        logic [7:0] e;
        n = 0;
        for (int i = 0; i < c_MTU; i++) begin
            e = (i < m_bytes.size()) ? m_bytes[i] : 8'h00;
            if (packet_data[i*8 +: 8] !== e) n++;
        end
        return n;
    endfunction

    // mode: 0 random bytes, 1 byte = stream index, 2 all 0xA5
    task automatic send_packet(input logic [c_UW-1:0] user, input int mode,
                               input int gap_max, input bit with_last);
        logic [c_DB*8-1:0] d;
        logic              rdy;
        int                waited;
        bit                timed_out;
        m_bytes.delete();
        m_total = 0;
        m_user  = user;
        foreach (keeps_q[k]) begin
            repeat ($urandom_range(gap_max, 0)) begin
                axis_if.tvalid = 1'b0;
                @(negedge clk);
            end
            for (int b = 0; b < c_DB; b++) begin
                if (b >= keeps_q[k] || mode == 0) d[b*8 +: 8] = 8'($urandom);
                else if (mode == 1)               d[b*8 +: 8] = 8'(m_total + b);
                else                              d[b*8 +: 8] = 8'hA5;
            end
            axis_if.tdata  = d;
            axis_if.tkeep  = 8'((1 << keeps_q[k]) - 1);
            axis_if.tlast  = with_last && (k == keeps_q.size() - 1);
            axis_if.tuser  = (k == 0) ? user : c_UW'($urandom);
            axis_if.tvalid = 1'b1;
            waited    = 0;
            timed_out = 1'b0;
            forever begin
                rdy = axis_if.tready;
                @(posedge clk);
                if (rdy) break;
                @(negedge clk);
                stalls++;
                waited++;
                if (waited > 1000) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_accept_timeout beat=%0d waited=%0d cycles, required acceptance", k, waited);
                    timed_out = 1'b1;
                    break;
                end
            end
            if (!timed_out) @(negedge clk);
            for (int b = 0; b < keeps_q[k]; b++) m_bytes.push_back(d[b*8 +: 8]);
            m_total += keeps_q[k];
        end
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
        axis_if.tkeep  = '0;
        axis_if.tdata  = '0;
        axis_if.tuser  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (axis_if.tready !== 1'b0 || packet_valid !== 1'b0 || busy !== 1'b0 || packet_overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags tready=%b valid=%b busy=%b ovf=%b, required all 0",
                     axis_if.tready, packet_valid, busy, packet_overflow);
        end
        checks++;
        if (packet_byte_length !== 0 || packet_user !== '0 || packet_data !== '0) begin
            failures++;
            $display("FAIL reset_values len=%0d user=%h data_nonzero=%b, required 0/0/0",
                     packet_byte_length, packet_user, |packet_data);
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if (axis_if.tready !== 1'b0) begin
            failures++;
            $display("FAIL ready_at_release tready=%b, required 0", axis_if.tready);
        end
        @(negedge clk);
        checks++;
        if (axis_if.tready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_edge tready=%b busy=%b, required 1/0", axis_if.tready, busy);
        end
    endtask

    task automatic test_full_beats();
        keeps_q = {8, 8, 8, 8, 8, 8, 8, 8};
        send_packet(4'h5, 1, 0, 1'b1);
        checks++;
        if (packet_valid !== 1'b1 || busy !== 1'b1 || axis_if.tready !== 1'b0) begin
            failures++;
            $display("FAIL full_valid valid=%b busy=%b tready=%b, required 1/1/0",
                     packet_valid, busy, axis_if.tready);
        end
        checks++;
        if (packet_byte_length !== 64 || packet_user !== 4'h5 || packet_overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_meta len=%0d user=%h ovf=%b, required 64/5/0",
                     packet_byte_length, packet_user, packet_overflow);
        end
        checks++;
        if (bad_bytes() !== 0) begin
            failures++;
            $display("FAIL full_data bad_bytes=%0d, required 0", bad_bytes());
        end
        packet_ack = 1'b1;
        @(negedge clk);
        packet_ack = 1'b0;
        checks++;
        if (packet_valid !== 1'b0 || packet_byte_length !== 0 || packet_overflow !== 1'b0 ||
            packet_data !== '0 || axis_if.tready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ack_clear valid=%b len=%0d ovf=%b data_nonzero=%b tready=%b busy=%b, required 0/0/0/0/1/0",
                     packet_valid, packet_byte_length, packet_overflow, |packet_data, axis_if.tready, busy);
        end
    endtask

    task automatic test_partial_keep();
        keeps_q = {8, 5};
        send_packet(c_UW'($urandom), 0, 1, 1'b1);
        checks++;
        if (packet_valid !== 1'b1 || packet_byte_length !== exp_len() || packet_overflow !== exp_ovf() ||
            packet_user !== m_user) begin
            failures++;
            $display("FAIL partial_meta valid=%b len=%0d ovf=%b user=%h, required 1/%0d/%b/%h",
                     packet_valid, packet_byte_length, packet_overflow, packet_user, exp_len(), exp_ovf(), m_user);
        end
        checks++;
        if (bad_bytes() !== 0) begin
            failures++;
            $display("FAIL partial_data bad_bytes=%0d, required 0", bad_bytes());
        end
        packet_ack = 1'b1;
        @(negedge clk);
        packet_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad_cycles;
        keeps_q = {8, 8, 8};
        send_packet(c_UW'($urandom), 0, 0, 1'b1);
        axis_if.tdata  = {$urandom, $urandom};
        axis_if.tkeep  = 8'hFF;
        axis_if.tuser  = c_UW'($urandom);
        axis_if.tvalid = 1'b1;
        bad_cycles = 0;
        repeat (10) begin
            @(negedge clk);
            if (axis_if.tready !== 1'b0 || packet_valid !== 1'b1 || packet_byte_length !== exp_len() ||
                packet_user !== m_user || bad_bytes() !== 0) bad_cycles++;
        end
        checks++;
        if (bad_cycles !== 0) begin
            failures++;
            $display("FAIL hold_stall bad_cycles=%0d, required 0 (tready 0, first packet stable)", bad_cycles);
        end
        packet_ack = 1'b1;
        @(negedge clk);
        packet_ack = 1'b0;
        checks++;
        if (axis_if.tready !== 1'b1 || packet_valid !== 1'b0) begin
            failures++;
            $display("FAIL ack_ready tready=%b valid=%b, required 1/0", axis_if.tready, packet_valid);
        end
        keeps_q = {8, 8, 5};
        send_packet(c_UW'($urandom), 0, 0, 1'b1);
        checks++;
        if (packet_valid !== 1'b1 || packet_byte_length !== exp_len() || packet_user !== m_user ||
            bad_bytes() !== 0) begin
            failures++;
            $display("FAIL second_packet valid=%b len=%0d user=%h bad_bytes=%0d, required 1/%0d/%h/0",
                     packet_valid, packet_byte_length, packet_user, bad_bytes(), exp_len(), m_user);
        end
        packet_ack = 1'b1;
        @(negedge clk);
        packet_ack = 1'b0;
    endtask

    task automatic test_overflow();
        int s0;
        keeps_q.delete();
        repeat (189) keeps_q.push_back(8);
        s0 = stalls;
        send_packet(4'hA, 1, 0, 1'b1);
        checks++;
        if (stalls !== s0) begin
            failures++;
            $display("FAIL overflow_ready stalls=%0d, required 0", stalls - s0);
        end
        checks++;
        if (packet_valid !== 1'b1 || packet_byte_length !== exp_len() || packet_overflow !== exp_ovf()) begin
            failures++;
            $display("FAIL overflow_meta valid=%b len=%0d ovf=%b, required 1/%0d/%b",
                     packet_valid, packet_byte_length, packet_overflow, exp_len(), exp_ovf());
        end
        checks++;
        if (packet_data[1499*8 +: 8] !== m_bytes[1499] || bad_bytes() !== 0) begin
            failures++;
            $display("FAIL overflow_data byte1499=%h bad_bytes=%0d, required %h/0",
                     packet_data[1499*8 +: 8], bad_bytes(), m_bytes[1499]);
        end
        packet_ack = 1'b1;
        @(negedge clk);
        packet_ack = 1'b0;
        checks++;
        if (packet_overflow !== 1'b0 || packet_byte_length !== 0) begin
            failures++;
            $display("FAIL overflow_ack ovf=%b len=%0d, required 0/0", packet_overflow, packet_byte_length);
        end
    endtask

    task automatic test_reset_mid_packet();
        keeps_q = {8, 8, 8};
        send_packet(c_UW'($urandom), 0, 0, 1'b0);
        axis_if.tvalid = 1'b1;
        axis_if.tkeep  = 8'hFF;
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (axis_if.tready !== 1'b0 || packet_valid !== 1'b0 || busy !== 1'b0 || packet_overflow !== 1'b0 ||
            packet_byte_length !== 0 || packet_user !== '0 || packet_data !== '0) begin
            failures++;
            $display("FAIL async_reset tready=%b valid=%b busy=%b ovf=%b len=%0d user=%h data_nonzero=%b, required all 0",
                     axis_if.tready, packet_valid, busy, packet_overflow, packet_byte_length, packet_user, |packet_data);
        end
        @(negedge clk);
        aresetn = 1'b1;
        keeps_q = {8, 2};
        send_packet(c_UW'($urandom), 0, 0, 1'b1);
        checks++;
        if (packet_valid !== 1'b1 || packet_byte_length !== 10 || packet_user !== m_user || bad_bytes() !== 0) begin
            failures++;
            $display("FAIL post_reset_packet valid=%b len=%0d user=%h bad_bytes=%0d, required 1/10/%h/0",
                     packet_valid, packet_byte_length, packet_user, bad_bytes(), m_user);
        end
        packet_ack = 1'b1;
        @(negedge clk);
        packet_ack = 1'b0;
    endtask

    task automatic test_ack_in_idle();
        packet_ack = 1'b1;
        @(negedge clk);
        packet_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || packet_valid !== 1'b0 || axis_if.tready !== 1'b1) begin
            failures++;
            $display("FAIL idle_ack busy=%b valid=%b tready=%b, required 0/0/1", busy, packet_valid, axis_if.tready);
        end
        keeps_q = {1};
        send_packet(4'h3, 2, 0, 1'b1);
        checks++;
        if (packet_valid !== 1'b1 || packet_byte_length !== 1 || packet_data[7:0] !== 8'hA5 || bad_bytes() !== 0) begin
            failures++;
            $display("FAIL single_byte valid=%b len=%0d byte0=%h bad_bytes=%0d, required 1/1/a5/0",
                     packet_valid, packet_byte_length, packet_data[7:0], bad_bytes());
        end
        packet_ack = 1'b1;
        @(negedge clk);
        packet_ack = 1'b0;
    endtask

    task automatic test_random();
        int nbeats;
        for (int p = 0; p < 20; p++) begin
            keeps_q.delete();
            nbeats = (p == 7) ? 200 : int'($urandom_range(6, 1));
            repeat (nbeats) keeps_q.push_back(($urandom_range(9, 0) < 7) ? 8 : int'($urandom_range(8, 0)));
            send_packet(c_UW'($urandom), 0, 2, 1'b1);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            checks++;
            if (packet_valid !== 1'b1 || packet_byte_length !== exp_len() || packet_overflow !== exp_ovf() ||
                packet_user !== m_user || bad_bytes() !== 0) begin
                failures++;
                $display("FAIL random_pkt%0d valid=%b len=%0d ovf=%b user=%h bad_bytes=%0d, required 1/%0d/%b/%h/0",
                         p, packet_valid, packet_byte_length, packet_overflow, packet_user, bad_bytes(),
                         exp_len(), exp_ovf(), m_user);
            end
            packet_ack = 1'b1;
            @(negedge clk);
            packet_ack = 1'b0;
            checks++;
            if (packet_valid !== 1'b0 || packet_byte_length !== 0 || packet_overflow !== 1'b0) begin
                failures++;
                $display("FAIL random_ack%0d valid=%b len=%0d ovf=%b, required 0/0/0",
                         p, packet_valid, packet_byte_length, packet_overflow);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_full_beats();
        test_partial_keep();
        test_back_to_back();
        test_overflow();
        test_reset_mid_packet();
        test_ack_in_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
